// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background SECDED memory scrubber
// Reads each word in turn, rewrites single-bit errors via the encoder, and logs double-bit errors.
module ecc_scrub_ctrl #(
  parameter int K        = 8,
  parameter int M        = 4,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int INTERVAL = 1024,
  parameter int CNT_W    = 16,
  localparam int CW      = K + M + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clear_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [CW-1:0]     mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [CW-1:0]     mem_rdata_i,
  output logic [CW-1:0]     dec_d_o,
  input  logic [K-1:0]      dec_q_i,
  input  logic              dec_sb_err_i,
  input  logic              dec_db_err_i,
  output logic [K-1:0]      enc_d_o,
  input  logic [CW-1:0]     enc_cw_i,
  output logic [CNT_W-1:0]  sb_cnt_o,
  output logic [CNT_W-1:0]  db_cnt_o,
  output logic [ADDR_W-1:0] db_addr_o,
  output logic              db_irq_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TW-1:0]     TRELOAD = TW'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CMAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ, S_NEXT
  } state_t;

  state_t state, nxt;
  logic [TW-1:0]     timer;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     cw_reg;
  logic [CW-1:0]     wdata_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (en_i) nxt = S_WAIT;
      S_WAIT:    if (!en_i) nxt = S_IDLE;
                 else if (timer == '0) nxt = S_RD_REQ;
      S_RD_REQ:  if (mem_gnt_i) nxt = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid_i) nxt = S_CHECK;
      // a double error wins over a simultaneous single-error flag
      S_CHECK:   nxt = (dec_sb_err_i && !dec_db_err_i) ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  if (mem_gnt_i) nxt = S_NEXT;
      S_NEXT:    nxt = en_i ? S_WAIT : S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    busy_o    = (state != S_IDLE);
    case (state)
      S_RD_REQ: mem_req_o = 1'b1;
      S_WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer     <= '0;
      addr      <= '0;
      cw_reg    <= '0;
      wdata_reg <= '0;
      db_addr_o <= '0;
      db_irq_o  <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      db_irq_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        S_IDLE:    if (en_i) timer <= TRELOAD;
        S_WAIT:    if (timer != '0) timer <= timer - TW'(1);
        S_RD_WAIT: if (mem_rvalid_i) cw_reg <= mem_rdata_i;
        S_CHECK: begin
          if (dec_db_err_i) begin
            db_addr_o <= addr;
            db_irq_o  <= 1'b1;
          end else if (dec_sb_err_i) begin
            wdata_reg <= enc_cw_i;
          end
        end
        S_NEXT: begin
          if (addr == LAST) begin
            addr   <= '0;
            done_o <= 1'b1;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
          if (en_i) timer <= TRELOAD;
        end
        default: ;
      endcase
    end
  end

  // clear takes priority over a same-cycle increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_cnt_o <= '0;
      db_cnt_o <= '0;
    end else if (clear_i) begin
      sb_cnt_o <= '0;
      db_cnt_o <= '0;
    end else if (state == S_CHECK) begin
      if (dec_db_err_i) begin
        if (db_cnt_o != CMAX) db_cnt_o <= db_cnt_o + CNT_W'(1);
      end else if (dec_sb_err_i) begin
        if (sb_cnt_o != CMAX) sb_cnt_o <= sb_cnt_o + CNT_W'(1);
      end
    end
  end

  assign mem_addr_o  = addr;
  assign mem_wdata_o = wdata_reg;
  assign dec_d_o     = cw_reg;
  assign enc_d_o     = dec_q_i;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb/tb_ecc_scrub_ctrl.sv - scoreboard bench for ecc_scrub_ctrl
// Memory accesses, db_irq and done pulses are matched in order against an expected-event queue.
module tb_ecc_scrub_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic        gnt_en = 1'b1;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [7:0]  mem_addr, db_addr;
  logic [12:0] mem_wdata, mem_rdata, dec_d, enc_cw;
  logic [7:0]  dec_q, enc_d;
  logic        dec_sb, dec_db;
  logic [1:0]  sb_cnt, db_cnt;
  logic        db_irq, done, busy;
  logic [9:0]  dres;

  logic [12:0] mem [4];
  logic        tb_wr = 1'b0;
  logic [1:0]  tb_addr = '0;
  logic [12:0] tb_data = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {int kind; logic [7:0] addr; logic [12:0] data;} ev_t;
  ev_t sb_q[$];

  always #5 clk = ~clk;

  ecc_scrub_ctrl #(.K(8), .M(4), .ADDR_W(8), .DEPTH(4), .INTERVAL(4), .CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .dec_d_o(dec_d), .dec_q_i(dec_q), .dec_sb_err_i(dec_sb), .dec_db_err_i(dec_db),
    .enc_d_o(enc_d), .enc_cw_i(enc_cw),
    .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt), .db_addr_o(db_addr),
    .db_irq_o(db_irq), .done_o(done), .busy_o(busy)
  );

  // Hamming(12,8): positions 1..12, parity at powers of two, bit 0 = overall parity
  function automatic logic [12:0] enc_f(input logic [7:0] d);
    logic [12:0] c;
    logic p;
    c = '0;
    {c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]} = d;
    for (int b = 1; b < 9; b = b * 2) begin
      p = 1'b0;
      for (int i = 1; i < 13; i++) if ((i & b) != 0) p = p ^ c[i];
      c[b] = p;
    end
    c[0] = ^c[12:1];
    return c;
  endfunction

  function automatic logic [9:0] dec_f(input logic [12:0] cw);
    logic [12:0] c;
    logic [3:0]  syn;
    logic        sb, db;
    c = cw;
    syn = '0;
    sb = 1'b0;
    db = 1'b0;
    for (int i = 1; i < 13; i++) if (c[i]) syn = syn ^ 4'(i);
    if (syn != 4'd0) begin
      if ((^c) && syn < 4'd13) begin
        sb = 1'b1;
        c[syn] = ~c[syn];
      end else begin
        db = 1'b1;
      end
    end
    return {sb, db, c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction

  assign dres    = dec_f(dec_d);
  assign dec_sb  = dres[9];
  assign dec_db  = dres[8];
  assign dec_q   = dres[7:0];
  assign enc_cw  = enc_f(enc_d);
  assign mem_gnt = mem_req & gnt_en;

  always @(posedge clk) begin
    if (tb_wr) mem[tb_addr] <= tb_data;
    else if (mem_req && mem_gnt && mem_we) mem[mem_addr[1:0]] <= mem_wdata;
    mem_rvalid <= !rst && mem_req && mem_gnt && !mem_we;
    mem_rdata  <= mem[mem_addr[1:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] a, input logic [12:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [7:0] a, input logic [12:0] d);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event: got kind %0d addr %0d data %0h, expected none", kind, a, d);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.addr !== a || (kind == 1 && e.data !== d)) begin
        errors++;
        $display("FAIL event: got kind %0d addr %0d data %0h, expected kind %0d addr %0d data %0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // kinds: 0 read, 1 write, 2 db_irq, 3 done
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_gnt) got(mem_we ? 1 : 0, mem_addr, mem_wdata);
      if (db_irq) got(2, db_addr, 13'd0);
      if (done) got(3, 8'd0, 13'd0);
    end
  end

  task automatic poke(input int a, input logic [12:0] d);
    @(posedge clk);
    #1;
    tb_wr = 1'b1;
    tb_addr = 2'(a);
    tb_data = d;
    @(posedge clk);
    #1;
    tb_wr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic settle(input string name);
    repeat (8) @(posedge clk);
    #1;
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_access(input string name, input logic want_we);
    int n;
    n = 0;
    @(negedge clk);
    while (!(mem_req && mem_gnt && mem_we == want_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(mem_req && mem_gnt && mem_we == want_we), 32'd1);
  endtask

  logic [7:0]  dval [4];
  logic [12:0] cw0, cw1, cw2, cw3;

  initial begin
    dval[0] = 8'h11; dval[1] = 8'h22; dval[2] = 8'h33; dval[3] = 8'h44;
    cw0 = enc_f(dval[0]); cw1 = enc_f(dval[1]); cw2 = enc_f(dval[2]); cw3 = enc_f(dval[3]);
    poke(0, cw0); poke(1, cw1); poke(2, cw2); poke(3, cw3);
    #1;
    check("rst_req", 32'(mem_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_cnts", 32'({sb_cnt, db_cnt, db_irq, done}), 0);
    check("rst_dec_d", 32'(dec_d), 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: clean pass
    push_ev(0, 0, 0); push_ev(0, 1, 0); push_ev(0, 2, 0); push_ev(0, 3, 0); push_ev(3, 0, 0);
    en = 1'b1;
    wait_drain("t1_drain");
    #1 en = 1'b0;
    settle("t1_idle");
    check("t1_sb_cnt", 32'(sb_cnt), 0);
    check("t1_db_cnt", 32'(db_cnt), 0);

    // 2: single-bit error in word 2 is rewritten
    poke(2, cw2 ^ 13'h0040);
    push_ev(0, 0, 0); push_ev(0, 1, 0); push_ev(0, 2, 0); push_ev(1, 2, cw2);
    push_ev(0, 3, 0); push_ev(3, 0, 0);
    en = 1'b1;
    wait_drain("t2_drain");
    #1 en = 1'b0;
    settle("t2_idle");
    check("t2_sb_cnt", 32'(sb_cnt), 1);
    check("t2_mem2", 32'(mem[2]), 32'(cw2));

    // 3: double-bit error in word 1 is logged, not written
    poke(1, cw1 ^ 13'h0028);
    push_ev(0, 0, 0); push_ev(0, 1, 0); push_ev(2, 1, 0); push_ev(0, 2, 0);
    push_ev(0, 3, 0); push_ev(3, 0, 0);
    en = 1'b1;
    wait_drain("t3_drain");
    #1 en = 1'b0;
    settle("t3_idle");
    check("t3_db_cnt", 32'(db_cnt), 1);
    check("t3_db_addr", 32'(db_addr), 1);
    check("t3_sb_cnt", 32'(sb_cnt), 1);
    poke(1, cw1);

    // 4: grant stall holds request; en drop in RD_WAIT ends at IDLE
    gnt_en = 1'b0;
    push_ev(0, 0, 0);
    en = 1'b1;
    begin
      int n;
      n = 0;
      while (!mem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t4_req_seen", 32'(mem_req), 1);
    for (int i = 0; i < 10; i++) begin
      check("t4_req_hold", 32'(mem_req), 1);
      check("t4_addr_hold", 32'(mem_addr), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 gnt_en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t4_idle", 32'(busy), 0);
    check("t4_addr_kept", 32'(mem_addr), 1);
    wait_drain("t4_drain_a");
    push_ev(0, 1, 0); push_ev(0, 2, 0); push_ev(0, 3, 0); push_ev(3, 0, 0);
    en = 1'b1;
    wait_drain("t4_drain_b");
    #1 en = 1'b0;
    settle("t4_idle_b");

    // 5: four more single-bit errors saturate the 2-bit counter
    poke(0, cw0 ^ 13'h0040); poke(1, cw1 ^ 13'h0040);
    poke(2, cw2 ^ 13'h0040); poke(3, cw3 ^ 13'h0040);
    push_ev(0, 0, 0); push_ev(1, 0, cw0); push_ev(0, 1, 0); push_ev(1, 1, cw1);
    push_ev(0, 2, 0); push_ev(1, 2, cw2); push_ev(0, 3, 0); push_ev(1, 3, cw3); push_ev(3, 0, 0);
    en = 1'b1;
    wait_drain("t5_drain");
    #1 en = 1'b0;
    settle("t5_idle");
    check("t5_sb_sat", 32'(sb_cnt), 3);
    poke(0, cw0 ^ 13'h0040);
    push_ev(0, 0, 0); push_ev(1, 0, cw0);
    en = 1'b1;
    wait_access("t5_rd_seen", 1'b0);
    @(posedge clk);
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0; en = 1'b0;
    wait_drain("t5_drain_b");
    settle("t5_idle_b");
    check("t5_clear_sb", 32'(sb_cnt), 0);
    check("t5_clear_db", 32'(db_cnt), 0);
    check("t5_addr", 32'(mem_addr), 1);

    // 6: reset during write-back aborts and restarts at address 0
    poke(1, cw1 ^ 13'h0040);
    push_ev(0, 1, 0); push_ev(1, 1, cw1);
    en = 1'b1;
    wait_access("t6_wr_seen", 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_req", 32'(mem_req), 0);
    check("t6_we", 32'(mem_we), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_addr", 32'(mem_addr), 0);
    check("t6_wdata", 32'(mem_wdata), 0);
    wait_drain("t6_drain_a");
    @(posedge clk); #1 rst = 1'b0;
    push_ev(0, 0, 0); push_ev(0, 1, 0); push_ev(1, 1, cw1);
    push_ev(0, 2, 0); push_ev(0, 3, 0); push_ev(3, 0, 0);
    wait_drain("t6_drain_b");
    #1 en = 1'b0;
    settle("t6_idle");
    check("t6_sb_cnt", 32'(sb_cnt), 1);
    check("t6_mem1", 32'(mem[1]), 32'(cw1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
